// File: rtl/common.sv
// Shared types for the machine core and its bus masters.
// Holds machine variants and the I/O master sequencing states.
package common;

    typedef enum logic [1:0] {
        MACHINE_48K,
        MACHINE_128K,
        MACHINE_PLUS3,
        MACHINE_PENTAGON
    } machine_t;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3,
        DONE
    } io_master_state_t;

    function automatic logic io_timed(input io_master_state_t s);
        return (s == T1) || (s == T2) || (s == TW) || (s == T3);
    endfunction

endpackage

// File: rtl/io_master_tstate_timer.sv
// T-state timer: counts clk28 cycles within one Z80 T-state.
// Flags the final clk28 of the T-state so the FSM can advance.
module tstate_timer #(
    parameter int TSTATE_CLKS = 8
) (
    input  logic clk28,
    input  logic rst,
    input  logic en,
    output logic last
);

    localparam int CW = (TSTATE_CLKS > 1) ? $clog2(TSTATE_CLKS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(TSTATE_CLKS - 1);

    logic [CW-1:0] tick;

    // restarts at zero on every T-state boundary, so it never wraps
    always_ff @(posedge clk28) begin
        if (rst) begin
            tick <= '0;
        end else if (!en || last) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign last = en && (tick == CMAX);

endmodule

// File: rtl/io_master.sv
// Z80-style I/O bus cycle master: T1, T2, auto TW, extra TWs, T3.
// Extra wait states are bounded; an overrun aborts with timeout.
module io_master
    import common::*;
#(
    parameter int TSTATE_CLKS = 8,
    parameter int WAIT_MAX    = 255
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  rdata,
    output logic [15:0] io_a,
    output logic        io_ioreq,
    output logic        io_rd,
    output logic        io_wr,
    output logic [7:0]  io_d_out,
    output logic        io_d_oe,
    input  logic [7:0]  io_d_in,
    input  logic        io_wait
);

    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WW-1:0] WLIM = WW'(WAIT_MAX);

    io_master_state_t state;
    logic             we_q;
    logic [WW-1:0]    wcnt;
    logic             wait_m;
    logic             wait_s;
    logic             last;

    tstate_timer #(
        .TSTATE_CLKS(TSTATE_CLKS)
    ) u_timer (
        .clk28(clk28),
        .rst  (rst),
        .en   (io_timed(state)),
        .last (last)
    );

    always_ff @(posedge clk28) begin
        if (rst) begin
            wait_m <= 1'b0;
            wait_s <= 1'b0;
        end else begin
            wait_m <= io_wait;
            wait_s <= wait_m;
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            wcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            rdata    <= 8'hFF;
            io_a     <= 16'h0000;
            io_ioreq <= 1'b0;
            io_rd    <= 1'b0;
            io_wr    <= 1'b0;
            io_d_out <= 8'h00;
            io_d_oe  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done    <= 1'b0;
                    timeout <= 1'b0;
                    if (req) begin
                        state    <= T1;
                        busy     <= 1'b1;
                        we_q     <= we;
                        wcnt     <= '0;
                        io_a     <= addr;
                        io_d_out <= wdata;
                        io_d_oe  <= we;
                    end
                end
                T1: begin
                    if (last) begin
                        state    <= T2;
                        io_ioreq <= 1'b1;
                        io_rd    <= ~we_q;
                        io_wr    <= we_q;
                    end
                end
                T2: begin
                    if (last) begin
                        state <= TW;
                    end
                end
                TW: begin
                    if (last) begin
                        if (!wait_s) begin
                            state <= T3;
                        end else if (wcnt != WLIM) begin
                            wcnt <= wcnt + 1'b1;
                        end else begin
                            // wait never released: abandon, keep old rdata
                            state    <= DONE;
                            timeout  <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            io_ioreq <= 1'b0;
                            io_rd    <= 1'b0;
                            io_wr    <= 1'b0;
                            io_d_oe  <= 1'b0;
                        end
                    end
                end
                T3: begin
                    if (last) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        io_ioreq <= 1'b0;
                        io_rd    <= 1'b0;
                        io_wr    <= 1'b0;
                        io_d_oe  <= 1'b0;
                        if (!we_q) begin
                            rdata <= io_d_in;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    timeout <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_master.sv
// Directed bench for io_master: write, read, waits, timeout,
// mid-cycle reset and req ignored while busy.
module tb_io_master;

    logic        clk28 = 1'b0;
    logic        rst;
    logic        req;
    logic        req2;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  io_d_in;
    logic        io_wait;

    logic        busy_a, done_a, timeout_a;
    logic [7:0]  rdata_a, dout_a;
    logic [15:0] ioa_a;
    logic        ioreq_a, rd_a, wr_a, oe_a;

    logic        busy_b, done_b, timeout_b;
    logic [7:0]  rdata_b, dout_b;
    logic [15:0] ioa_b;
    logic        ioreq_b, rd_b, wr_b, oe_b;

    int checks = 0;
    int errors = 0;
    int n, wrs, oes, rds, dones;
    logic to;

    always #5 clk28 = ~clk28;

    io_master u_dut_a (
        .clk28   (clk28),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy_a),
        .done    (done_a),
        .timeout (timeout_a),
        .rdata   (rdata_a),
        .io_a    (ioa_a),
        .io_ioreq(ioreq_a),
        .io_rd   (rd_a),
        .io_wr   (wr_a),
        .io_d_out(dout_a),
        .io_d_oe (oe_a),
        .io_d_in (io_d_in),
        .io_wait (io_wait)
    );

    io_master #(
        .TSTATE_CLKS(8),
        .WAIT_MAX   (4)
    ) u_dut_b (
        .clk28   (clk28),
        .rst     (rst),
        .req     (req2),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy_b),
        .done    (done_b),
        .timeout (timeout_b),
        .rdata   (rdata_b),
        .io_a    (ioa_b),
        .io_ioreq(ioreq_b),
        .io_rd   (rd_b),
        .io_wr   (wr_b),
        .io_d_out(dout_b),
        .io_d_oe (oe_b),
        .io_d_in (io_d_in),
        .io_wait (io_wait)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk28);
        #1;
    endtask

    task automatic issue(input bit b, input logic w,
                         input logic [15:0] a, input logic [7:0] d);
        we    = w;
        addr  = a;
        wdata = d;
        if (b) req2 = 1'b1;
        else   req  = 1'b1;
        step();
        req  = 1'b0;
        req2 = 1'b0;
    endtask

    // n = 1 on the first cycle after acceptance; returns the cycle of done
    task automatic run(input bit b, input int won, input int woff,
                       output int cyc, output int nwr, output int noe,
                       output int nrd, output logic tout);
        bit fin;
        fin  = 0;
        cyc  = 1;
        nwr  = 0;
        noe  = 0;
        nrd  = 0;
        tout = 1'b0;
        while (!fin) begin
            if (cyc == won)  io_wait = 1'b1;
            if (cyc == woff) io_wait = 1'b0;
            if (b ? done_b : done_a) begin
                tout = b ? timeout_b : timeout_a;
                fin  = 1;
            end else if (cyc >= 300) begin
                cyc = -1;
                fin = 1;
            end else begin
                nwr += int'(b ? wr_b : wr_a);
                noe += int'(b ? oe_b : oe_a);
                nrd += int'(b ? rd_b : rd_a);
                step();
                cyc++;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        req     = 1'b0;
        req2    = 1'b0;
        we      = 1'b0;
        addr    = 16'h0000;
        wdata   = 8'h00;
        io_d_in = 8'h00;
        io_wait = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_rdata", 32'(rdata_a), 32'hFF);
        check("rst_io_a", 32'(ioa_a), 32'h0);
        check("rst_strobes", {29'd0, ioreq_a, rd_a, wr_a}, 32'd0);
        rst = 1'b0;
        step();

        issue(1'b0, 1'b1, 16'h7FFD, 8'h10);
        check("wr_busy", 32'(busy_a), 32'd1);
        check("wr_io_a", 32'(ioa_a), 32'h7FFD);
        run(1'b0, 0, 0, n, wrs, oes, rds, to);
        check("wr_done_cyc", 32'(n), 32'd33);
        check("wr_wr_len", 32'(wrs), 32'd24);
        check("wr_oe_len", 32'(oes), 32'd32);
        check("wr_rd_len", 32'(rds), 32'd0);
        check("wr_timeout", 32'(to), 32'd0);
        check("wr_dout", 32'(dout_a), 32'h10);
        check("wr_done_busy", 32'(busy_a), 32'd0);
        step();
        check("wr_idle_done", 32'(done_a), 32'd0);
        check("wr_idle_io_a", 32'(ioa_a), 32'h7FFD);

        io_d_in = 8'hBF;
        issue(1'b0, 1'b0, 16'h00FE, 8'h55);
        run(1'b0, 0, 0, n, wrs, oes, rds, to);
        check("rd_done_cyc", 32'(n), 32'd33);
        check("rd_rdata", 32'(rdata_a), 32'hBF);
        check("rd_oe_len", 32'(oes), 32'd0);
        check("rd_rd_len", 32'(rds), 32'd24);
        check("rd_io_a", 32'(ioa_a), 32'h00FE);
        step();
        io_d_in = 8'h11;
        step();
        check("rd_rdata_hold", 32'(rdata_a), 32'hBF);

        io_d_in = 8'h3C;
        issue(1'b0, 1'b0, 16'h00FE, 8'h00);
        run(1'b0, 12, 44, n, wrs, oes, rds, to);
        check("wait_done_cyc", 32'(n), 32'd57);
        check("wait_timeout", 32'(to), 32'd0);
        check("wait_rd_len", 32'(rds), 32'd48);
        check("wait_rdata", 32'(rdata_a), 32'h3C);
        step();
        step();

        io_d_in = 8'h5A;
        issue(1'b1, 1'b0, 16'h1234, 8'h00);
        run(1'b1, 0, 0, n, wrs, oes, rds, to);
        check("b_rd_done_cyc", 32'(n), 32'd33);
        check("b_rd_rdata", 32'(rdata_b), 32'h5A);
        step();
        step();

        io_d_in = 8'h77;
        io_wait = 1'b1;
        issue(1'b1, 1'b0, 16'h00FE, 8'h00);
        run(1'b1, 0, 0, n, wrs, oes, rds, to);
        check("to_done_cyc", 32'(n), 32'd57);
        check("to_timeout", 32'(to), 32'd1);
        check("to_rd_len", 32'(rds), 32'd48);
        check("to_rdata_kept", 32'(rdata_b), 32'h5A);
        check("to_strobes", {29'd0, ioreq_b, rd_b, oe_b}, 32'd0);
        io_wait = 1'b0;
        step();
        check("to_timeout_clr", 32'(timeout_b), 32'd0);
        step();

        issue(1'b0, 1'b1, 16'hBEEF, 8'hA5);
        for (int i = 1; i < 12; i++) step();
        check("rs_mid_ioreq", 32'(ioreq_a), 32'd1);
        rst = 1'b1;
        step();
        check("rs_strobes", {28'd0, ioreq_a, rd_a, wr_a, oe_a}, 32'd0);
        check("rs_busy", 32'(busy_a), 32'd0);
        check("rs_io_a", 32'(ioa_a), 32'h0);
        check("rs_dout", 32'(dout_a), 32'h0);
        check("rs_rdata", 32'(rdata_a), 32'hFF);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            dones += int'(done_a);
            step();
        end
        check("rs_no_done", 32'(dones), 32'd0);
        issue(1'b0, 1'b1, 16'h7FFD, 8'h17);
        run(1'b0, 0, 0, n, wrs, oes, rds, to);
        check("rs_new_cyc", 32'(n), 32'd33);
        check("rs_new_wr_len", 32'(wrs), 32'd24);
        step();
        step();

        issue(1'b0, 1'b1, 16'h1FFD, 8'h07);
        dones = 0;
        n     = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 28) begin
                we   = 1'b0;
                addr = 16'hFFFF;
                req  = 1'b1;
            end
            if (c == 29) req = 1'b0;
            if (done_a) begin
                dones++;
                n = c;
            end
            step();
        end
        check("t3req_dones", 32'(dones), 32'd1);
        check("t3req_done_cyc", 32'(n), 32'd33);
        check("t3req_busy", 32'(busy_a), 32'd0);
        check("t3req_io_a", 32'(ioa_a), 32'h1FFD);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
